imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the decode path.
- Takes instruction bits [31:7] with an explicit extension-type code and produces the sign/zero-extended immediate, XLEN bits wide.
- Elastic valid/ready pipeline of configurable depth, with flush and a sideband tag (PC) carried alongside.
- Adds an explicit shift-amount mode and a CSR-uimm mode. Shift detection no longer relies on funct3.

Parameters:
- XLEN, 32, output width; legal values 32 or 64.
- STAGES, 1, pipeline depth = latency in cycles; legal values 1 or 2.
- TAG_W, 32, width of the sideband tag.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  kill all in-flight entries
- in_valid  in  1  input entry valid
- in_ready  out  1  block can accept an entry this cycle
- in_op  in  3  extension type (encoding below)
- in_din  in  25  instruction bits; in_din[i] = instr[i+7]
- in_tag  in  TAG_W  sideband, passed through unchanged
- out_valid  out  1  output entry valid
- out_ready  in  1  consumer accepts the output entry
- out_imm  out  XLEN  extended immediate
- out_tag  out  TAG_W  tag of the output entry
- out_err  out  1  entry had an illegal or NONE op

Behaviour:
- Reset: when rst_n = 0 at a clock edge, all stage valids = 0, out_imm = 0, out_tag = 0, out_err = 0.
- Op encoding, with s = instr[31] sign-replicated to XLEN:
  - 0 NONE: all ones; out_err = 1.
  - 1 I: s : instr[30:20].
  - 2 S: s : instr[30:25] : instr[11:7].
  - 3 B: s : instr[7] : instr[30:25] : instr[11:8] : 0.
  - 4 U: s above bit 31, then instr[31:12] : 12'b0. XLEN=64 sign-extends from bit 31.
  - 5 J: s : instr[19:12] : instr[20] : instr[30:21] : 0.
  - 6 Z: zero-extended instr[19:15] (CSR uimm).
  - 7 SH: zero-extended instr[25:20] masked to log2(XLEN) bits (5 for RV32, 6 for RV64).
  - Only op 0 sets out_err. All 3-bit codes are defined.
- Extension is computed combinationally on the input and registered in stage 0. With STAGES=2, stage 1 is a pure register copy.
- Each stage holds valid, imm, tag and err. Stage k loads when it is empty or its downstream consumer takes it this cycle:
  - For the last stage, "taken" means out_valid & out_ready.
  - For other stages, "taken" means the next stage loads.
- in_ready = stage 0 empty OR stage 0 advancing this cycle. It is combinational from out_ready, so there are no bubbles and throughput is 1 entry per cycle.
- Transfer on input occurs when in_valid & in_ready. Transfer on output occurs when out_valid & out_ready.
- Latency: an entry accepted at edge N is presented at out_* after edge N+STAGES-1 (valid from the cycle after acceptance for STAGES=1).
- Stall: while out_valid & !out_ready, out_imm, out_tag and out_err stay bit-stable. Upstream entries are preserved and none are dropped or duplicated.
- Data registers update only on load. They are not cleared when a stage empties; only the valid bit clears.
- flush = 1 at an edge:
  - All valids clear at that edge.
  - An input offered in the same cycle is discarded, even if in_ready = 1.
  - in_ready during flush still reflects normal state; the discard is internal.
- Flush and reset both clear valids. Reset also clears data.
- Reset or flush mid-stall: the pending entry is lost, and out_valid = 0 on the next cycle.
- Illegal parameters (XLEN not 32/64, STAGES not 1/2) must fail elaboration.

Test Plan:
- XLEN=32, STAGES=1, out_ready=1, op I with instr 0xFFF00093 -> out_imm 0xFFFFFFFF, out_err 0, one cycle after acceptance. The same entry with XLEN=64 -> 0xFFFFFFFFFFFFFFFF.
- Back-to-back, one per cycle, out_ready=1:
  - B 0xFE000EE3 -> 0xFFFFFFFC
  - U 0x123450B7 -> 0x12345000
  - J 0x001000EF -> 0x00000800
  - S 0xFE112E23 -> 0xFFFFFFFC
  - Each result appears on consecutive cycles with its matching tag.
- SH 0x41F0D093 -> 0x1F for XLEN=32; SH with instr[25]=1, shamt 63 -> 0x3F for XLEN=64 and 0x1F for XLEN=32. Z with instr[19:15]=0x1F -> 0x1F. NONE -> all ones with out_err 1.
- STAGES=2, out_ready held 0, three entries offered -> two accepted, in_ready 0 on the third, and out_* stable. On release, all three emerge in order with no gaps.
- Flush with two entries in flight plus a concurrent in_valid -> out_valid 0 the next cycle and the offered entry is never output. rst_n=0 during a stall -> all outputs 0.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: extends instr[31:7] by op code into an XLEN immediate
// and carries it with a sideband tag through an elastic valid/ready pipeline.
module imm_gen_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [24:0]      in_din,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    generate
        if (!(XLEN == 32 || XLEN == 64) || !(STAGES == 1 || STAGES == 2)) begin : g_bad_param
            $error("imm_gen_pipe: XLEN must be 32 or 64 and STAGES must be 1 or 2");
        end
    endgenerate

    // Keep the architectural bit numbering so the field slices read like the ISA manual.
    logic [31:7]     ins;
    logic [31:0]     imm32;
    logic            sext;
    logic            sh_hi;
    logic [XLEN-1:0] ext_imm;
    logic            ext_err;

    assign ins   = in_din;
    assign sh_hi = (XLEN == 64) ? ins[25] : 1'b0;

    always_comb begin
        imm32   = '0;
        sext    = 1'b1;
        ext_err = 1'b0;
        case (in_op)
            3'd0: begin
                imm32   = '1;
                ext_err = 1'b1;
            end
            3'd1: imm32 = {{20{ins[31]}}, ins[31:20]};
            3'd2: imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            3'd3: imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            3'd4: imm32 = {ins[31:12], 12'b0};
            3'd5: imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            3'd6: begin
                imm32 = {27'b0, ins[19:15]};
                sext  = 1'b0;
            end
            default: begin
                imm32 = {26'b0, sh_hi, ins[24:20]};
                sext  = 1'b0;
            end
        endcase
        ext_imm = sext ? XLEN'($signed(imm32)) : XLEN'(imm32);
    end

    logic [STAGES-1:0] valid_vec;
    logic [XLEN-1:0]   imm_arr [STAGES];
    logic [TAG_W-1:0]  tag_arr [STAGES];
    logic [STAGES-1:0] err_vec;
    logic [STAGES:0]   rdy;

    // rdy[k] = stage k may load this cycle; walks back from the consumer so a full pipe still streams.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !valid_vec[k] | rdy[k+1];
        end
    end

    assign in_ready = rdy[0];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic             valid_reg;
            logic [XLEN-1:0]  imm_reg;
            logic [TAG_W-1:0] tag_reg;
            logic             err_reg;
            logic             src_valid;
            logic [XLEN-1:0]  src_imm;
            logic [TAG_W-1:0] src_tag;
            logic             src_err;

            if (gi == 0) begin : g_src_in
                assign src_valid = in_valid;
                assign src_imm   = ext_imm;
                assign src_tag   = in_tag;
                assign src_err   = ext_err;
            end else begin : g_src_prev
                assign src_valid = valid_vec[gi-1];
                assign src_imm   = imm_arr[gi-1];
                assign src_tag   = tag_arr[gi-1];
                assign src_err   = err_vec[gi-1];
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    imm_reg   <= '0;
                    tag_reg   <= '0;
                    err_reg   <= 1'b0;
                end else if (flush) begin
                    valid_reg <= 1'b0;
                end else if (rdy[gi]) begin
                    valid_reg <= src_valid;
                    if (src_valid) begin
                        imm_reg <= src_imm;
                        tag_reg <= src_tag;
                        err_reg <= src_err;
                    end
                end
            end

            assign valid_vec[gi] = valid_reg;
            assign imm_arr[gi]   = imm_reg;
            assign tag_arr[gi]   = tag_reg;
            assign err_vec[gi]   = err_reg;
        end
    endgenerate

    assign out_valid = valid_vec[STAGES-1];
    assign out_imm   = imm_arr[STAGES-1];
    assign out_tag   = tag_arr[STAGES-1];
    assign out_err   = err_vec[STAGES-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: an XLEN=32/STAGES=1 and an XLEN=64/STAGES=2 instance
// share one stimulus stream; each has its own expected-result queue.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [2:0]  in_op;
    logic [24:0] in_din;
    logic [31:0] in_tag;

    logic        in_ready_a, out_valid_a, out_err_a;
    logic [31:0] out_imm_a, out_tag_a;
    logic        in_ready_b, out_valid_b, out_err_b;
    logic [63:0] out_imm_b;
    logic [31:0] out_tag_b;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .STAGES(1), .TAG_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_op(in_op), .in_din(in_din), .in_tag(in_tag), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_imm(out_imm_a), .out_tag(out_tag_a), .out_err(out_err_a)
    );

    imm_gen_pipe #(.XLEN(64), .STAGES(2), .TAG_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_op(in_op), .in_din(in_din), .in_tag(in_tag), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_imm(out_imm_b), .out_tag(out_tag_b), .out_err(out_err_b)
    );

    typedef struct packed {
        logic [63:0] imm;
        logic [31:0] tag;
        logic        err;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] cur_instr = '0;
    logic [31:0] next_tag  = 32'h100;
    logic        use_exp   = 1'b0;
    logic [63:0] exp32_v   = '0;
    logic [63:0] exp64_v   = '0;
    logic        exp_err_v = 1'b0;

    // Reference: gather the immediate fields as a signed number, then truncate to XLEN.
    function automatic logic [63:0] ref_imm(input logic [2:0] op, input logic [31:0] i, input int xlen);
        longint v;
        case (op)
            3'd0:    v = -1;
            3'd1:    v = longint'($signed(i[31:20]));
            3'd2:    v = longint'($signed({i[31:25], i[11:7]}));
            3'd3:    v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            3'd4:    v = longint'($signed({i[31:12], 12'h000}));
            3'd5:    v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            3'd6:    v = longint'(i[19:15]);
            default: v = longint'(i[25:20]) % xlen;
        endcase
        if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor + scoreboard: sample between edges, pop on output transfers, push on input transfers.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid_a && out_ready) begin
            $display("tx a tag=%08h imm=%08h err=%0d", out_tag_a, out_imm_a, out_err_a);
            if (q_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_a_unexpected: got tag %h expected no output", out_tag_a);
            end else begin
                e = q_a.pop_front();
                check("sb_a_imm", {32'b0, out_imm_a}, e.imm);
                check("sb_a_tag", {32'b0, out_tag_a}, {32'b0, e.tag});
                check("sb_a_err", {63'b0, out_err_a}, {63'b0, e.err});
            end
        end
        if (out_valid_b && out_ready) begin
            $display("tx b tag=%08h imm=%016h err=%0d", out_tag_b, out_imm_b, out_err_b);
            if (q_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_b_unexpected: got tag %h expected no output", out_tag_b);
            end else begin
                e = q_b.pop_front();
                check("sb_b_imm", out_imm_b, e.imm);
                check("sb_b_tag", {32'b0, out_tag_b}, {32'b0, e.tag});
                check("sb_b_err", {63'b0, out_err_b}, {63'b0, e.err});
            end
        end
        if (!rst_n || flush) begin
            q_a.delete();
            q_b.delete();
        end else if (in_valid) begin
            e.tag = in_tag;
            e.err = use_exp ? exp_err_v : (in_op == 3'd0);
            if (in_ready_a) begin
                e.imm = use_exp ? exp32_v : ref_imm(in_op, cur_instr, 32);
                q_a.push_back(e);
            end
            if (in_ready_b) begin
                e.imm = use_exp ? exp64_v : ref_imm(in_op, cur_instr, 64);
                q_b.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] ins);
        in_valid  = 1'b1;
        in_op     = op;
        cur_instr = ins;
        in_din    = ins[31:7];
        in_tag    = next_tag;
        next_tag  = next_tag + 1;
    endtask

    task automatic directed(input logic [2:0] op, input logic [31:0] ins,
                            input logic [63:0] e32, input logic [63:0] e64, input logic err);
        use_exp   = 1'b1;
        exp32_v   = e32;
        exp64_v   = e64;
        exp_err_v = err;
        drive(op, ins);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        use_exp  = 1'b0;
    endtask

    task automatic zero_checks(input string p);
        check({p, "_a_valid"}, {63'b0, out_valid_a}, 64'd0);
        check({p, "_a_imm"}, {32'b0, out_imm_a}, 64'd0);
        check({p, "_a_tag"}, {32'b0, out_tag_a}, 64'd0);
        check({p, "_a_err"}, {63'b0, out_err_a}, 64'd0);
        check({p, "_b_valid"}, {63'b0, out_valid_b}, 64'd0);
        check({p, "_b_imm"}, out_imm_b, 64'd0);
        check({p, "_b_tag"}, {32'b0, out_tag_b}, 64'd0);
        check({p, "_b_err"}, {63'b0, out_err_b}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200us");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  v_op  [8] = '{3'd3, 3'd4, 3'd5, 3'd2, 3'd7, 3'd7, 3'd6, 3'd0};
        logic [31:0] v_ins [8] = '{32'hFE000EE3, 32'h123450B7, 32'h001000EF, 32'hFE112E23,
                                   32'h41F0D093, 32'h03F00093, 32'h000F8073, 32'h00000013};
        logic [63:0] v_e32 [8] = '{64'hFFFFFFFC, 64'h12345000, 64'h00000800, 64'hFFFFFFFC,
                                   64'h1F, 64'h1F, 64'h1F, 64'hFFFFFFFF};
        logic [63:0] v_e64 [8] = '{64'hFFFFFFFF_FFFFFFFC, 64'h12345000, 64'h800, 64'hFFFFFFFF_FFFFFFFC,
                                   64'h1F, 64'h3F, 64'h1F, 64'hFFFFFFFF_FFFFFFFF};
        logic [31:0] t [3];
        logic [2:0]  op1;
        logic [31:0] ins1;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_din = '0; in_tag = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        zero_checks("reset");
        rst_n = 1'b1;
        tick();

        // Latency: STAGES=1 shows the entry one edge after acceptance, STAGES=2 one edge later.
        t[0] = next_tag;
        directed(3'd1, 32'hFFF00093, 64'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
        tick();
        idle();
        check("lat_a_valid", {63'b0, out_valid_a}, 64'd1);
        check("lat_a_tag", {32'b0, out_tag_a}, {32'b0, t[0]});
        check("lat_b_not_yet", {63'b0, out_valid_b}, 64'd0);
        tick();
        check("lat_b_valid", {63'b0, out_valid_b}, 64'd1);
        check("lat_a_drained", {63'b0, out_valid_a}, 64'd0);
        tick();

        // Back-to-back directed vectors, one per cycle, no gaps on the STAGES=1 output.
        for (int i = 0; i < 8; i++) begin
            t[0] = next_tag;
            directed(v_op[i], v_ins[i], v_e32[i], v_e64[i], v_op[i] == 3'd0);
            tick();
            check("b2b_a_valid", {63'b0, out_valid_a}, 64'd1);
            check("b2b_a_tag", {32'b0, out_tag_a}, {32'b0, t[0]});
        end
        idle();
        repeat (3) tick();

        // Stall on STAGES=2: two accepted, third refused, output held steady.
        out_ready = 1'b0;
        op1  = 3'd1;
        ins1 = $urandom;
        t[0] = next_tag;
        drive(op1, ins1);
        #1 check("stall_rdy1", {63'b0, in_ready_b}, 64'd1);
        tick();
        t[1] = next_tag;
        drive(3'($urandom_range(0, 7)), $urandom);
        #1 check("stall_rdy2", {63'b0, in_ready_b}, 64'd1);
        tick();
        t[2] = next_tag;
        drive(3'($urandom_range(0, 7)), $urandom);
        #1 check("stall_rdy3", {63'b0, in_ready_b}, 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_b_valid", {63'b0, out_valid_b}, 64'd1);
            check("stall_b_tag", {32'b0, out_tag_b}, {32'b0, t[0]});
            check("stall_b_imm", out_imm_b, ref_imm(op1, ins1, 64));
            check("stall_b_rdy", {63'b0, in_ready_b}, 64'd0);
        end
        out_ready = 1'b1;
        #1 check("release_rdy", {63'b0, in_ready_b}, 64'd1);
        for (int k = 0; k < 3; k++) begin
            check("release_b_valid", {63'b0, out_valid_b}, 64'd1);
            check("release_b_tag", {32'b0, out_tag_b}, {32'b0, t[k]});
            tick();
            if (k == 0) idle();
        end
        repeat (3) tick();

        // Flush with entries in flight and a concurrent offer.
        out_ready = 1'b0;
        drive(3'd2, $urandom);
        tick();
        drive(3'd5, $urandom);
        tick();
        drive(3'd4, $urandom);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        check("flush_a_valid", {63'b0, out_valid_a}, 64'd0);
        check("flush_b_valid", {63'b0, out_valid_b}, 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("flush_idle", {62'b0, out_valid_a, out_valid_b}, 64'd0);
        end

        // Reset in the middle of a stall.
        out_ready = 1'b0;
        drive(3'd3, $urandom);
        tick();
        drive(3'd1, $urandom);
        tick();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        zero_checks("stall_reset");
        out_ready = 1'b1;
        tick();

        // Random traffic with random backpressure and occasional flushes.
        for (int n = 0; n < 400; n++) begin
            flush     = ($urandom_range(0, 49) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) drive(3'($urandom_range(0, 7)), $urandom);
            else in_valid = 1'b0;
            tick();
        end
        flush = 1'b0;
        idle();
        out_ready = 1'b1;
        repeat (6) tick();
        check("drain_a_empty", 64'(q_a.size()), 64'd0);
        check("drain_b_empty", 64'(q_b.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
